clkgate_en_ctrl: RTL
====================

# clkgate_en_ctrl

Enable controller that drives the E and SE pins of a CLKGATETST-style integrated clock-gating cell. It watches activity requests from the gated domain, opens the gate on demand, holds off the requester until the gated clock has restarted, and closes the gate after a programmable idle run. It sits in the free-running CK domain, directly upstream of the clock-gate cell.

## Interface
- IDLE_CYCLES, 16, consecutive idle CK edges in ON before the gate closes; legal range 1..1023.
- WAKE_CYCLES, 2, CK edges spent in WAKE before ACK may assert; legal range 1..15.
- CNT_W, 16, width of the gate-close event counter.
- CK  in  1  free-running clock; same clock that feeds the gate cell.
- RN  in  1  asynchronous active-low reset.
- REQ  in  1  level request for gated-clock service.
- BUSY  in  1  gated-domain busy indication; counts as activity but never receives ACK.
- FORCE_ON  in  1  software override; holds the gate open while high.
- TE  in  1  scan/test enable.
- E  out  1  registered functional enable to the gate cell.
- SE  out  1  test enable to the gate cell; SE = TE, combinational.
- ACK  out  1  REQ granted; gated clock is running.
- GATE_CNT  out  CNT_W  saturating count of ON->OFF transitions.

## Operation
- Activity is defined as (REQ | BUSY | FORCE_ON).
- States: OFF, WAKE, ON. Reset state is OFF.
- OFF: E=0. Activity sampled high at an edge moves the FSM to WAKE and sets E=1. The wake counter loads 0.
- WAKE: E=1. The wake counter increments each edge. When it reaches WAKE_CYCLES-1, the next edge moves the FSM to ON and clears the idle counter. Loss of activity in WAKE does not abort; the FSM still goes to ON.
- ON: E=1. An edge with no activity increments the idle counter. An edge with activity clears it.
- Gate close: at an idle edge where the idle counter equals IDLE_CYCLES-1, the FSM moves to OFF, E goes 0, and GATE_CNT increments. GATE_CNT holds at all-ones once saturated.
- ACK = (state==ON) & REQ. It is combinational from registered state, so it never asserts in OFF or WAKE.
- TE has no effect on the FSM. It is forwarded unchanged to SE.
- Width rules:
  - Idle counter: 10 bits.
  - Wake counter: 4 bits.
  - Counters never wrap; their compare values are bounded by the parameters.

## Timing
- All state, E, counters and GATE_CNT update on posedge CK.
- E changes only just after posedge CK, which meets the gate cell's setup requirement to the next posedge.
- Reset values: state OFF, E=0, ACK=0, GATE_CNT=0, all counters 0. SE follows TE even during reset.
- RN low mid-operation: E drops immediately (asynchronously). This is glitch-safe because the gate cell's latch is closed while CK is high.
- Latency from REQ to ACK:
  - REQ high from OFF, sampled at edge t: E=1 after t, state ON after edge t+WAKE_CYCLES, ACK high in cycle t+WAKE_CYCLES.
  - REQ high in ON: ACK is high in the same cycle.
- Latency from the last activity edge to close: E falls after the IDLE_CYCLES-th consecutive idle edge.
- Simultaneous events:
  - Activity arriving on the same edge as the close compare keeps the FSM in ON and clears the idle counter.
  - Activity in the cycle after close restarts at WAKE; no OFF dwell is required.

## Structure
- Package clkgate_ctrl_pkg holds:
  - state enum typedef (OFF, WAKE, ON);
  - idle counter width constant (10) and wake counter width constant (4);
  - parameter-range check macros/functions.
- One sub-module, cg_sat_counter (CNT_W, inc, clr, q, saturating), is used for GATE_CNT.
- Idle and wake counters are coded inline.
- Elaboration asserts on illegal IDLE_CYCLES or WAKE_CYCLES.

## Test plan
- Reset, then idle for 50 cycles: E=0, ACK=0, GATE_CNT=0; SE tracks a TE toggle with zero cycles of delay.
- Defaults, REQ=1 sampled at edge 10: E=1 after edge 10, ACK first high in cycle 12. Drop REQ at edge 20: E falls after edge 36, GATE_CNT=1.
- REQ pulses again on the exact edge where the idle counter equals 15: FSM stays ON, E stays 1, idle counter returns to 0, GATE_CNT is unchanged.
- BUSY=1 with REQ=0 from OFF: E=1, FSM reaches ON, ACK stays 0 throughout. Gate closes 16 edges after BUSY falls.
- FORCE_ON=1 for 100 cycles with no REQ: E stays 1 and no close occurs. Dropping FORCE_ON gives a close 16 edges later.
- Pull RN low mid-WAKE: E=0 and ACK=0 immediately. On release with REQ=1, the full WAKE latency is repeated. Run 65540 forced open/close cycles with CNT_W=16: GATE_CNT saturates at 65535.

Source files
------------

// File: rtl/clkgate_ctrl_pkg.sv
// rtl/clkgate_ctrl_pkg.sv - shared types, widths and parameter checks for the clock-gate enable controller
//
// Purpose: state encoding, internal counter widths and legality checks for
//          IDLE_CYCLES / WAKE_CYCLES used by clkgate_en_ctrl.
// Ports:   none (package).
package clkgate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_e;

  localparam int IDLE_CNT_W = 10;
  localparam int WAKE_CNT_W = 4;

  function automatic bit idle_cycles_ok(input int v);
    return (v >= 1) && (v <= 1023);
  endfunction

  function automatic bit wake_cycles_ok(input int v);
    return (v >= 1) && (v <= 15);
  endfunction

endpackage

// File: rtl/cg_sat_counter.sv
// rtl/cg_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses, sticks at all-ones, clr wins over inc.
// Ports:   clk   in   clock
//          rst_n in   asynchronous active-low reset
//          inc   in   increment request
//          clr   in   synchronous clear
//          q     out  [CNT_W-1:0] count
module cg_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/clkgate_en_ctrl.sv
// rtl/clkgate_en_ctrl.sv - E/SE driver for an integrated clock-gating cell
//
// Purpose: opens the gate on activity, holds ACK off for WAKE_CYCLES while the
//          gated clock restarts, closes after IDLE_CYCLES idle edges in ON.
// Ports:   CK       in   free-running clock (also feeds the gate cell)
//          RN       in   asynchronous active-low reset
//          REQ      in   level request for gated-clock service
//          BUSY     in   gated-domain busy, activity without ACK
//          FORCE_ON in   software hold-open
//          TE       in   scan/test enable
//          E        out  registered functional enable
//          SE       out  test enable, combinational copy of TE
//          ACK      out  REQ granted while in ON
//          GATE_CNT out  [CNT_W-1:0] saturating ON->OFF count
module clkgate_en_ctrl
  import clkgate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             REQ,
  input  logic             BUSY,
  input  logic             FORCE_ON,
  input  logic             TE,
  output logic             E,
  output logic             SE,
  output logic             ACK,
  output logic [CNT_W-1:0] GATE_CNT
);

  generate
    if (!idle_cycles_ok(IDLE_CYCLES)) begin : g_bad_idle
      $error("clkgate_en_ctrl: IDLE_CYCLES out of range 1..1023");
    end
    if (!wake_cycles_ok(WAKE_CYCLES)) begin : g_bad_wake
      $error("clkgate_en_ctrl: WAKE_CYCLES out of range 1..15");
    end
  endgenerate

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    e_q, e_d;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                    close_evt;
  logic                    activity;

  assign activity = REQ | BUSY | FORCE_ON;

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    close_evt  = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (activity) begin
          state_d    = ST_WAKE;
          e_d        = 1'b1;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Wake runs to completion regardless of activity so the gated
        // clock is guaranteed stable before any ACK.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_ON;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        // Activity has priority over the close compare on the same edge.
        if (activity) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d   = ST_OFF;
          e_d       = 1'b0;
          close_evt = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        e_d     = 1'b0;
      end
    endcase
  end

  // Async reset drops E while CK may be high; the cell latch is closed then.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_OFF;
      e_q        <= 1'b0;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  cg_sat_counter #(.CNT_W(CNT_W)) u_gate_cnt (
    .clk   (CK),
    .rst_n (RN),
    .inc   (close_evt),
    .clr   (1'b0),
    .q     (GATE_CNT)
  );

  assign E   = e_q;
  assign SE  = TE;
  assign ACK = (state_q == ST_ON) & REQ;

endmodule
